mult_seq_n_bit: RTL and testbench



---
 rtl/mult_seq_n_bit_pkg.sv | 15 +
 rtl/mult_seq_n_bit_adder.sv | 18 +
 rtl/mult_seq_n_bit.sv | 93 +++++++++
 tb/tb_mult_seq_n_bit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mult_seq_n_bit_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and the counter-width helper.
package mult_seq_n_bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_seq_n_bit_adder.sv
// N-bit ripple adder shared by the ALU units: unsigned sum with carry-out plus signed overflow flag.
module ADDER_N_BIT #(
  parameter int size = 4
) (
  input  logic [size-1:0] in_a,
  input  logic [size-1:0] in_b,
  input  logic            cin,
  output logic [size-1:0] sum,
  output logic            cout,
  output logic            overflow
);

  assign {cout, sum} = {1'b0, in_a} + {1'b0, in_b} + {{size{1'b0}}, cin};

  // Two's-complement overflow: like-signed operands yielding a differently signed result.
  assign overflow = (in_a[size-1] == in_b[size-1]) && (sum[size-1] != in_a[size-1]);

endmodule

// File: rtl/mult_seq_n_bit.sv
// Sequential unsigned shift-and-add multiplier: size iterations per product, one-cycle done pulse.
module mult_seq_n_bit
  import mult_seq_n_bit_pkg::*;
#(
  parameter int size = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [size-1:0]   in_a,
  input  logic [size-1:0]   in_b,
  output logic [2*size-1:0] out,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  state_t              state;
  logic [CW-1:0]       count;
  logic [2*size-1:0]   shreg;   // {acc, mplr}
  logic [size-1:0]     mcand;

  logic [size-1:0]     add_sum;
  logic                add_cout;
  logic [size-1:0]     acc_next;
  logic                carry;
  logic [2*size-1:0]   shift_next;

  ADDER_N_BIT #(.size(size)) u_adder (
    .in_a     (shreg[2*size-1:size]),
    .in_b     (mcand),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow ()
  );

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    carry    = 1'b0;
    acc_next = shreg[2*size-1:size];
    if (shreg[0]) begin
      carry    = add_cout;
      acc_next = add_sum;
    end
    // {c, sum, mplr} >> 1, truncated to 2*size bits: the carry lands in the MSB.
    shift_next = {carry, acc_next, shreg[size-1:1]};
  end

  assign busy = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
      mcand <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= in_a;
            shreg <= {{size{1'b0}}, in_b};
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          shreg <= shift_next;
          if (count == LAST) begin
            // Final iteration: publish the product on entry to DONE; count stays put, no wrap.
            state <= DONE;
            out   <= shift_next;
            done  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_n_bit.sv
// Scoreboard bench for mult_seq_n_bit at size 4 and size 8, randomized plus directed corner cases.
module tb_mult_seq_n_bit;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int sz, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (size=%0d) at %0t: got %0d, expected %0d", name, sz, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int SZ = (g == 0) ? 4 : 8;

    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic [SZ-1:0]     in_a    = '0;
    logic [SZ-1:0]     in_b    = '0;
    logic [2*SZ-1:0]   out;
    logic              busy;
    logic              done;

    int          cyc     = 0;
    int          win_lo  = 1;
    int          win_hi  = 0;
    logic [63:0] hold_out = '0;
    exp_t        q[$];
    bit          fin = 1'b0;

    mult_seq_n_bit #(.size(SZ)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .in_a    (in_a),
      .in_b    (in_b),
      .out     (out),
      .busy    (busy),
      .done    (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample 1 time unit after each edge, compare against the model state.
    always @(posedge clk) begin
      #1;
      check("busy", SZ, 64'(busy), 64'(cyc >= win_lo && cyc <= win_hi));
      if (done) begin
        if (q.size() == 0) begin
          check("done_unexpected", SZ, 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("latency", SZ, 64'(cyc), 64'(e.due));
          check("product", SZ, 64'(out), e.prod);
          hold_out = e.prod;
        end
      end else begin
        check("out_hold", SZ, 64'(out), hold_out);
        if (q.size() > 0 && cyc > q[0].due) begin
          check("done_missing", SZ, 64'(done), 64'd1);
          void'(q.pop_front());
        end
      end
    end

    // Drive a start at the current negedge; the accepting edge E0 leaves cyc == k.
    task automatic issue(input logic [SZ-1:0] a, input logic [SZ-1:0] b, output int k);
      exp_t e;
      start  = 1'b1;
      in_a   = a;
      in_b   = b;
      k      = cyc + 1;
      e.prod = 64'(a) * 64'(b);
      e.due  = k + SZ;
      q.push_back(e);
      win_lo = k;
      win_hi = k + SZ;
      @(negedge clk);
      start = 1'b0;
      in_a  = SZ'($urandom);
      in_b  = SZ'($urandom);
    endtask

    // Full operation; returns at the negedge of the first IDLE cycle.
    task automatic run_op(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
      int k;
      issue(a, b, k);
      while (cyc < k + SZ + 1) @(negedge clk);
    endtask

    initial begin
      int k;
      logic [SZ-1:0] ones;
      ones = '1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      run_op(SZ'(3), SZ'(5));
      run_op(ones, ones);
      run_op(SZ'(0), SZ'(9));
      run_op(SZ'(9), SZ'(0));
      run_op(SZ'(10), SZ'(10));
      run_op(SZ'(4), SZ'(12));

      // start held high with changing operands through RUN and DONE
      issue(SZ'(6), SZ'(7), k);
      start = 1'b1;
      while (cyc < k + SZ + 1) begin
        start = 1'b1;
        in_a  = SZ'(2);
        in_b  = SZ'(2);
        @(negedge clk);
      end
      run_op(SZ'(2), SZ'(2));

      // reset on the second RUN cycle discards the operation
      issue(SZ'(13), SZ'(11), k);
      @(negedge clk);
      reset_n = 1'b0;
      q.delete();
      win_hi   = cyc;
      hold_out = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (SZ + 3) @(negedge clk);
      run_op(SZ'(2), SZ'(3));

      for (int i = 0; i < 25; i++) begin
        run_op(SZ'($urandom), SZ'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (SZ + 3) @(negedge clk);
      check("scoreboard_drained", SZ, 64'(q.size()), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    wait (lane[0].fin && lane[1].fin);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
